// File: rtl/mode_extreme_tracker_pkg.sv
// Shared FSM state encoding and mode constants for the frame extreme tracker.
// Pure declarations: no latency, no flow control.
package mode_extreme_tracker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/mode_extreme_tracker_compare_cell.sv
// Combinational strict "a beats b" test: a>b in max mode, a<b in min mode; zero latency, no flow control.
// MODE_EXTREME_SIGNED_EN selects two's-complement ordering, otherwise unsigned.
module mode_compare_cell
    import mode_extreme_tracker_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_mode,
    output logic             o_beats
);

    logic w_gt;
    logic w_lt;

`ifdef MODE_EXTREME_SIGNED_EN
    assign w_gt = $signed(i_a) > $signed(i_b);
    assign w_lt = $signed(i_a) < $signed(i_b);
`else
    assign w_gt = i_a > i_b;
    assign w_lt = i_a < i_b;
`endif

    // Strict compare keeps the earliest index on ties.
    assign o_beats = (i_mode == MODE_MIN) ? w_lt : w_gt;

endmodule

// File: rtl/mode_extreme_tracker.sv
// Tracks max/min over FRAME_LEN accepted samples; result valid one cycle after the last accept, held until out_ready.
// in_ready drops while a result is pending; MODE_EXTREME_SIGNED_EN switches to signed comparison.
module mode_extreme_tracker
    import mode_extreme_tracker_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [IDX_W-1:0] y_idx,
    output logic             y_mode
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_count;
    logic [WIDTH-1:0] r_best;
    logic [IDX_W-1:0] r_best_idx;
    logic             r_mode;
    logic [WIDTH-1:0] r_y;
    logic [IDX_W-1:0] r_y_idx;
    logic             r_y_mode;

    logic             w_accept;
    logic             w_first;
    logic             w_last;
    logic             w_beats;
    logic             w_take;
    logic [WIDTH-1:0] w_cand_best;
    logic [IDX_W-1:0] w_cand_idx;
    logic             w_cand_mode;

    mode_compare_cell #(.WIDTH(WIDTH)) u_cmp (
        .i_a     (din),
        .i_b     (r_best),
        .i_mode  (r_mode),
        .o_beats (w_beats)
    );

    assign w_accept    = in_valid && in_ready;
    assign w_first     = (r_count == '0);
    assign w_last      = (r_count == LAST_IDX);
    // Sample 0 always loads; its mode comes straight from m, not the stale latch.
    assign w_take      = w_first || w_beats;
    assign w_cand_best = w_take ? din : r_best;
    assign w_cand_idx  = w_take ? r_count : r_best_idx;
    assign w_cand_mode = w_first ? m : r_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_ACCUM;
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (clr) begin
                    w_next_state = ST_IDLE;
                end else if (w_accept && w_last) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (clr) begin
                    w_next_state = ST_IDLE;
                end else if (out_ready) begin
                    w_next_state = ST_ACCUM;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_mode     <= MODE_MAX;
            r_y        <= '0;
            r_y_idx    <= '0;
            r_y_mode   <= MODE_MAX;
        end else if (clr) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_best     <= w_cand_best;
            r_best_idx <= w_cand_idx;
            r_mode     <= w_cand_mode;
            if (w_last) begin
                r_count  <= '0;
                r_y      <= w_cand_best;
                r_y_idx  <= w_cand_idx;
                r_y_mode <= w_cand_mode;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign y      = r_y;
    assign y_idx  = r_y_idx;
    assign y_mode = r_y_mode;

endmodule

// File: tb/tb_mode_extreme_tracker.sv
// Scoreboard bench for mode_extreme_tracker (FRAME_LEN=4): directed frames plus randomized frames against a frame-level model.
module tb_mode_extreme_tracker;

    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 4;
    localparam int IDX_W     = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             m = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] din = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] y;
    logic [IDX_W-1:0] y_idx;
    logic             y_mode;

    typedef struct packed {
        logic [7:0] y;
        logic [1:0] idx;
        logic       mode;
    } res_t;

    int         checks = 0;
    int         errors = 0;
    res_t       exp_q[$];
    logic [7:0] frame_q[$];
    logic       frame_mode = 1'b0;
    int         rdy_policy = 2;
    logic       hold_prev = 1'b0;
    logic       hs_prev = 1'b0;

    mode_extreme_tracker #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m         (m),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_idx     (y_idx),
        .y_mode    (y_mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Maps a sample onto an unsigned ordering key matching the build's comparison.
    function automatic logic [7:0] order_key(input logic [7:0] v);
`ifdef MODE_EXTREME_SIGNED_EN
        return v ^ 8'h80;
`else
        return v;
`endif
    endfunction

    // Extreme value of the frame, then the first position holding it.
    function automatic res_t model();
        res_t       r;
        logic [7:0] ext;
        ext = order_key(frame_q[0]);
        foreach (frame_q[i]) begin
            if (frame_mode ? (order_key(frame_q[i]) < ext) : (order_key(frame_q[i]) > ext))
                ext = order_key(frame_q[i]);
        end
        r = '0;
        for (int i = FRAME_LEN - 1; i >= 0; i--) begin
            if (order_key(frame_q[i]) == ext) begin
                r.y   = frame_q[i];
                r.idx = IDX_W'(i);
            end
        end
        r.mode = frame_mode;
        return r;
    endfunction

    task automatic send(input logic [7:0] d, input logic mv);
        int n;
        n        = 0;
        din      = d;
        m        = mv;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (frame_q.size() == 0) frame_mode = mv;
        frame_q.push_back(d);
        if (frame_q.size() == FRAME_LEN) begin
            exp_q.push_back(model());
            frame_q.delete();
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        frame_q.delete();
        exp_q.delete();
    endtask

    task automatic drain();
        int n;
        n          = 0;
        rdy_policy = 2;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_policy)
            0:       out_ready = 1'($urandom_range(0, 1));
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor: every presented result is compared with the head of the expected queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
            hs_prev   = 1'b0;
        end else begin
            if (hold_prev) check("hold_out_valid", out_valid, 1);
            if (hs_prev) check("in_ready_after_handshake", in_ready, 1);
            hold_prev = 1'b0;
            hs_prev   = 1'b0;
            if (out_valid) begin
                check("in_ready_low_in_hold", in_ready, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: y=%0h idx=%0d with no frame pending", y, y_idx);
                end else begin
                    check("y", y, exp_q[0].y);
                    check("y_idx", y_idx, exp_q[0].idx);
                    check("y_mode", y_mode, exp_q[0].mode);
                    if (!clr) begin
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            hs_prev = 1'b1;
                        end else begin
                            hold_prev = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_y_idx", y_idx, 0);
        check("rst_y_mode", y_mode, 0);
        #11 rst_n = 1'b1;
        #2 check("idle_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("accum_after_reset", in_ready, 1);

        // Max frame, unsigned values, back-to-back.
        send(8'd3, 1'b0); send(8'd200, 1'b0); send(8'd17, 1'b0); send(8'd200, 1'b0);
        check("latency_out_valid", out_valid, 1);
        check("t1_y", y, 200);
        check("t1_idx", y_idx, 1);
        drain();

        // Min frame with gaps and a mode toggle after the first sample.
        send(8'd50, 1'b1); gap(2);
        send(8'd9, 1'b0);  gap(2);
        send(8'd9, 1'b0);  gap(2);
        send(8'd120, 1'b0);
        check("t2_y_mode", y_mode, 1);
        drain();

        // Backpressure: result held for several cycles.
        rdy_policy = 1;
        gap(1);
        send(8'd77, 1'b1); send(8'd12, 1'b1); send(8'd90, 1'b1); send(8'd12, 1'b1);
        gap(5);
        check("bp_out_valid", out_valid, 1);
        drain();
        gap(1);

        // Abort a partial frame.
        send(8'd250, 1'b0); send(8'd251, 1'b0);
        do_clr();
        gap(3);
        check("clr_out_valid", out_valid, 0);
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
        check("clr_next_y", y, 4);
        check("clr_next_idx", y_idx, 3);
        drain();

        // Asynchronous reset while the third sample is offered.
        send(8'd10, 1'b0); send(8'd20, 1'b0);
        din = 8'd30; in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_y", y, 0);
        check("arst_y_idx", y_idx, 0);
        check("arst_y_mode", y_mode, 0);
        #2;
        rst_n = 1'b1;
        in_valid = 1'b0;
        frame_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        check("arst_recover_in_ready", in_ready, 1);
        send(8'd5, 1'b1); send(8'd8, 1'b1); send(8'd2, 1'b1); send(8'd6, 1'b1);
        drain();

        // Sign-sensitive vector.
        send(8'hFF, 1'b0); send(8'h01, 1'b0); send(8'h80, 1'b0); send(8'h7F, 1'b0);
`ifdef MODE_EXTREME_SIGNED_EN
        check("sign_y", y, 8'h7F);
        check("sign_idx", y_idx, 3);
`else
        check("sign_y", y, 8'hFF);
        check("sign_idx", y_idx, 0);
`endif
        drain();

        // Randomized frames with random gaps, modes, backpressure and occasional aborts.
        rdy_policy = 0;
        for (int f = 0; f < 60; f++) begin
            for (int s = 0; s < FRAME_LEN; s++) begin
                logic [7:0] d;
                d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                send(d, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
                if ($urandom_range(0, 24) == 0) do_clr();
            end
        end
        drain();
        gap(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
